// File: rtl/wb_dbg_pkg.sv
// Shared types and constants for the byte-serial Wishbone debug master.
// Defines the FSM states, the response status codes and the command-byte fields.
package wb_dbg_pkg;

    typedef enum logic [2:0] {
        ST_CMD,
        ST_ADDR,
        ST_WDATA,
        ST_BUS,
        ST_STATUS,
        ST_RDATA
    } state_t;

    localparam logic [7:0] STAT_OK      = 8'h00;
    localparam logic [7:0] STAT_TIMEOUT = 8'h01;
    localparam logic [7:0] STAT_BADCMD  = 8'h02;

    localparam int CMD_WE_BIT = 7;
    localparam int CMD_RSV_HI = 6;
    localparam int CMD_RSV_LO = 4;
    localparam int CMD_SEL_HI = 3;
    localparam int CMD_SEL_LO = 0;

    // Reserved bits must be zero, otherwise the command is rejected without a bus cycle.
    function automatic logic isValidCmd(input logic [7:0] b);
        return b[CMD_RSV_HI:CMD_RSV_LO] == 3'b000;
    endfunction

endpackage

// File: rtl/wb_dbg_master_if.sv
// Byte command/response stream plus Wishbone initiator signals of the debug master.
// The master modport is the debug master itself; slave is the byte source/sink and bus side.
interface wb_dbg_master_if;

    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [0:23] adr_o;
    logic        cyc_o;
    logic        stb_o;
    logic        we_o;
    logic [0:3]  sel_o;
    logic [0:31] dat_o;
    logic [0:31] dat_i;
    logic        ack_i;

    modport master (
        input  in_data, in_valid, out_ready, dat_i, ack_i,
        output in_ready, out_data, out_valid, adr_o, cyc_o, stb_o, we_o, sel_o, dat_o
    );

    modport slave (
        output in_data, in_valid, out_ready, dat_i, ack_i,
        input  in_ready, out_data, out_valid, adr_o, cyc_o, stb_o, we_o, sel_o, dat_o
    );

endinterface

// File: rtl/wb_dbg_master.sv
// Turns a byte-serial command stream into single Wishbone cycles and frames a
// status (plus read data) response back onto the byte sink.
module wb_dbg_master
    import wb_dbg_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
)
(
    input  logic            clk,
    input  logic            reset,
    wb_dbg_master_if.master bus,
    output logic            busy
);

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    logic [1:0]  r_cnt;
    logic        r_we;
    logic [0:3]  r_sel;
    logic [0:21] r_adr;
    logic [0:31] r_dat;
    logic [0:31] r_rdata;
    logic        r_cyc;
    logic        r_stb;
    logic [15:0] r_tmo;
    logic [7:0]  r_status;
    logic [7:0]  r_out_data;
    logic        r_out_valid;

    logic        w_in_ready;
    logic        w_in_fire;
    logic        w_out_fire;
    logic        w_tmo_hit;

    assign w_in_ready = (r_state == ST_CMD) || (r_state == ST_ADDR) || (r_state == ST_WDATA);
    assign w_in_fire  = bus.in_valid && w_in_ready;
    assign w_out_fire = r_out_valid && bus.out_ready;
    assign w_tmo_hit  = (r_tmo == TMO_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_CMD;
            r_cnt       <= 2'd0;
            r_we        <= 1'b0;
            r_sel       <= '0;
            r_adr       <= '0;
            r_dat       <= '0;
            r_rdata     <= '0;
            r_cyc       <= 1'b0;
            r_stb       <= 1'b0;
            r_tmo       <= '0;
            r_status    <= STAT_OK;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            unique case (r_state)
                ST_CMD: begin
                    if (w_in_fire) begin
                        r_cnt <= 2'd0;
                        if (!isValidCmd(bus.in_data)) begin
                            r_status    <= STAT_BADCMD;
                            r_out_data  <= STAT_BADCMD;
                            r_out_valid <= 1'b1;
                            r_state     <= ST_STATUS;
                        end else begin
                            r_we    <= bus.in_data[CMD_WE_BIT];
                            r_sel   <= bus.in_data[CMD_SEL_HI:CMD_SEL_LO];
                            r_state <= ST_ADDR;
                        end
                    end
                end
                ST_ADDR: begin
                    // The two word-offset bits of the last byte are dropped, keeping adr_o word aligned.
                    if (w_in_fire) begin
                        r_cnt <= r_cnt + 2'd1;
                        case (r_cnt)
                            2'd0:    r_adr[0:7]   <= bus.in_data;
                            2'd1:    r_adr[8:15]  <= bus.in_data;
                            default: r_adr[16:21] <= bus.in_data[7:2];
                        endcase
                        if (r_cnt == 2'd2) begin
                            r_cnt <= 2'd0;
                            if (r_we) begin
                                r_state <= ST_WDATA;
                            end else begin
                                r_state <= ST_BUS;
                                r_cyc   <= 1'b1;
                                r_stb   <= 1'b1;
                                r_tmo   <= '0;
                            end
                        end
                    end
                end
                ST_WDATA: begin
                    if (w_in_fire) begin
                        r_dat <= {r_dat[8:31], bus.in_data};
                        r_cnt <= r_cnt + 2'd1;
                        if (r_cnt == 2'd3) begin
                            r_cnt   <= 2'd0;
                            r_state <= ST_BUS;
                            r_cyc   <= 1'b1;
                            r_stb   <= 1'b1;
                            r_tmo   <= '0;
                        end
                    end
                end
                ST_BUS: begin
                    // stb is always high here; an ack coinciding with the last timeout cycle still succeeds.
                    if (bus.ack_i || w_tmo_hit) begin
                        r_cyc       <= 1'b0;
                        r_stb       <= 1'b0;
                        r_rdata     <= bus.ack_i ? bus.dat_i : '0;
                        r_status    <= bus.ack_i ? STAT_OK : STAT_TIMEOUT;
                        r_out_data  <= bus.ack_i ? STAT_OK : STAT_TIMEOUT;
                        r_out_valid <= 1'b1;
                        r_cnt       <= 2'd0;
                        r_state     <= ST_STATUS;
                    end else begin
                        r_tmo <= r_tmo + 16'd1;
                    end
                end
                ST_STATUS: begin
                    if (w_out_fire) begin
                        r_cnt <= 2'd0;
                        if (!r_we && (r_status != STAT_BADCMD)) begin
                            r_out_data <= r_rdata[0:7];
                            r_rdata    <= {r_rdata[8:31], 8'h00};
                            r_state    <= ST_RDATA;
                        end else begin
                            r_out_valid <= 1'b0;
                            r_state     <= ST_CMD;
                        end
                    end
                end
                ST_RDATA: begin
                    if (w_out_fire) begin
                        if (r_cnt == 2'd3) begin
                            r_cnt       <= 2'd0;
                            r_out_valid <= 1'b0;
                            r_state     <= ST_CMD;
                        end else begin
                            r_cnt      <= r_cnt + 2'd1;
                            r_out_data <= r_rdata[0:7];
                            r_rdata    <= {r_rdata[8:31], 8'h00};
                        end
                    end
                end
                default: r_state <= ST_CMD;
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_data  = r_out_data;
    assign bus.out_valid = r_out_valid;
    assign bus.adr_o     = {r_adr, 2'b00};
    assign bus.cyc_o     = r_cyc;
    assign bus.stb_o     = r_stb;
    assign bus.we_o      = r_we;
    assign bus.sel_o     = r_sel;
    assign bus.dat_o     = r_dat;
    assign busy          = (r_state != ST_CMD);

endmodule
